// File: rtl/ioctl_arb_pkg.sv
// Shared types for the ioctl/core memory arbiter: FSM states and FIFO entry sizing.
// No logic; imported by the arbiter and its download FIFO.
package ioctl_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LD_WR = 2'd1,
        LD_RD = 2'd2,
        CORE  = 2'd3
    } arb_state_e;

    localparam int DATA_W = 8;

    // A FIFO entry carries the translated memory address above the data byte.
    function automatic int entry_width(input int aw);
        return aw + DATA_W;
    endfunction

endpackage

// File: rtl/ioctl_wr_fifo.sv
// Synchronous FIFO for download bytes, 2^LOG2 deep, head visible combinationally.
// Push while full is refused unless a pop frees the slot in the same cycle.
module ioctl_wr_fifo #(
    parameter int W    = 32,
    parameter int LOG2 = 2
) (
    input  logic         clk_sys,
    input  logic         reset,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int DEPTH = 1 << LOG2;

    logic [W-1:0]    mem_q [DEPTH];
    logic [LOG2-1:0] wr_ptr_q;
    logic [LOG2-1:0] rd_ptr_q;
    logic [LOG2:0]   count_q;
    logic            do_push;
    logic            do_pop;

    // Count tops out at exactly DEPTH, so its MSB alone marks full.
    assign full_o  = count_q[LOG2];
    assign empty_o = (count_q == '0);
    assign rdata_o = mem_q[rd_ptr_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/ioctl_mem_arbiter.sv
// Shares one memory port between data_io downloads/uploads and the core; loader always wins.
// Core: req->mem_req 1 cycle, mem_ack->core_ack 1 cycle; the memory stalls us by holding off mem_ack.
module ioctl_mem_arbiter
    import ioctl_arb_pkg::*;
#(
    parameter int            AW        = 24,
    parameter logic [AW-1:0] ADDR_BASE = '0,
    parameter int            FIFO_LOG2 = 2
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          ioctl_download,
    input  logic          ioctl_upload,
    input  logic          ioctl_wr,
    input  logic [26:0]   ioctl_addr,
    input  logic [7:0]    ioctl_dout,
    output logic [7:0]    ioctl_din,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [7:0]    core_wdata,
    output logic [7:0]    core_rdata,
    output logic          core_ack,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata,
    input  logic          mem_ack,
    output logic          loader_busy,
    output logic          overflow
);

    localparam int EW = entry_width(AW);

    arb_state_e    state_q, state_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]    mem_wdata_q, mem_wdata_d;
    logic          core_ack_q, core_ack_d;
    logic [7:0]    core_rdata_q, core_rdata_d;
    logic [7:0]    ioctl_din_q, ioctl_din_d;
    logic          rd_pend_q, rd_pend_d;
    logic          rd_dirty_q, rd_dirty_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic          overflow_q, overflow_d;
    logic          loader_busy_q, loader_busy_d;
    logic [26:0]   prev_addr_q;
    logic          upload_q;
    logic          download_q;

    logic [AW-1:0] ld_addr;
    logic          rd_trig;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [EW-1:0] fifo_head;

    assign ld_addr   = ADDR_BASE + ioctl_addr[AW-1:0];
    assign rd_trig   = ioctl_upload && (!upload_q || (ioctl_addr != prev_addr_q));
    assign fifo_push = ioctl_wr && ioctl_download;

    ioctl_wr_fifo #(
        .W    (EW),
        .LOG2 (FIFO_LOG2)
    ) u_wr_fifo (
        .clk_sys (clk_sys),
        .reset   (reset),
        .push_i  (fifo_push),
        .wdata_i ({ld_addr, ioctl_dout}),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d      = state_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        core_ack_d   = 1'b0;
        core_rdata_d = core_rdata_q;
        ioctl_din_d  = ioctl_din_q;
        fifo_pop     = 1'b0;
        rd_pend_d    = rd_pend_q | rd_trig;
        rd_dirty_d   = rd_dirty_q | rd_trig;
        rd_addr_d    = rd_trig ? ld_addr : rd_addr_q;

        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d     = LD_WR;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = fifo_head[EW-1:8];
                    mem_wdata_d = fifo_head[7:0];
                    fifo_pop    = 1'b1;
                end else if (rd_pend_q) begin
                    state_d    = LD_RD;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = rd_addr_q;
                    rd_dirty_d = rd_trig;
                end else if (core_req && !core_ack_q) begin
                    // core_req is still high in the cycle core_ack is out; don't replay it
                    state_d     = CORE;
                    mem_req_d   = 1'b1;
                    mem_we_d    = core_we;
                    mem_addr_d  = core_addr;
                    mem_wdata_d = core_wdata;
                end
            end
            LD_WR: begin
                if (mem_ack) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                end
            end
            LD_RD: begin
                if (mem_ack) begin
                    state_d     = IDLE;
                    mem_req_d   = 1'b0;
                    ioctl_din_d = mem_rdata;
                    rd_pend_d   = rd_dirty_q | rd_trig;
                end
            end
            CORE: begin
                if (mem_ack) begin
                    state_d    = IDLE;
                    mem_req_d  = 1'b0;
                    core_ack_d = 1'b1;
                    if (!mem_we_q) core_rdata_d = mem_rdata;
                end
            end
            default: state_d = IDLE;
        endcase

        overflow_d = overflow_q;
        if (ioctl_download && !download_q) overflow_d = 1'b0;
        if (fifo_push && fifo_full && !fifo_pop) overflow_d = 1'b1;

        loader_busy_d = ioctl_download | ioctl_upload | !fifo_empty | rd_pend_q
                      | (state_q == LD_WR) | (state_q == LD_RD);
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q       <= IDLE;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            core_ack_q    <= 1'b0;
            core_rdata_q  <= '0;
            ioctl_din_q   <= '0;
            rd_pend_q     <= 1'b0;
            rd_dirty_q    <= 1'b0;
            rd_addr_q     <= '0;
            overflow_q    <= 1'b0;
            loader_busy_q <= 1'b0;
            prev_addr_q   <= '0;
            upload_q      <= 1'b0;
            download_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            core_ack_q    <= core_ack_d;
            core_rdata_q  <= core_rdata_d;
            ioctl_din_q   <= ioctl_din_d;
            rd_pend_q     <= rd_pend_d;
            rd_dirty_q    <= rd_dirty_d;
            rd_addr_q     <= rd_addr_d;
            overflow_q    <= overflow_d;
            loader_busy_q <= loader_busy_d;
            prev_addr_q   <= ioctl_addr;
            upload_q      <= ioctl_upload;
            download_q    <= ioctl_download;
        end
    end

    assign ioctl_din   = ioctl_din_q;
    assign core_rdata  = core_rdata_q;
    assign core_ack    = core_ack_q;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign loader_busy = loader_busy_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_ioctl_mem_arbiter.sv
// Directed bench for ioctl_mem_arbiter with ADDR_BASE=0x200000, AW=24, 4-deep FIFO.
// Memory model acks 2 cycles after mem_req and returns rdata = addr[7:0] + 0x2C.
module tb_ioctl_mem_arbiter;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_download, ioctl_upload, ioctl_wr;
    logic [26:0] ioctl_addr;
    logic [7:0]  ioctl_dout, ioctl_din;
    logic        core_req, core_we, core_ack;
    logic [23:0] core_addr, mem_addr;
    logic [7:0]  core_wdata, core_rdata, mem_wdata, mem_rdata;
    logic        mem_req, mem_we, mem_ack, loader_busy, overflow;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [26:0] addr;
        logic [7:0]  dout;
        logic [23:0] exp_addr;
    } vec_t;

    typedef struct {
        logic        we;
        logic [23:0] addr;
        logic [7:0]  wdata;
    } txn_t;

    txn_t log_q[$];
    logic ack_en    = 1'b0;
    logic stray_ack = 1'b0;
    int   ack_cnt   = 0;

    ioctl_mem_arbiter #(
        .AW        (24),
        .ADDR_BASE (24'h200000),
        .FIFO_LOG2 (2)
    ) dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_upload   (ioctl_upload),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_din      (ioctl_din),
        .core_req       (core_req),
        .core_we        (core_we),
        .core_addr      (core_addr),
        .core_wdata     (core_wdata),
        .core_rdata     (core_rdata),
        .core_ack       (core_ack),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_ack        (mem_ack),
        .loader_busy    (loader_busy),
        .overflow       (overflow)
    );

    initial forever #5 clk_sys = ~clk_sys;

    // Memory responder: acts on the falling edge so the DUT samples stable inputs.
    initial begin
        int wait_cnt;
        wait_cnt  = 0;
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
        forever begin
            @(negedge clk_sys);
            mem_ack = 1'b0;
            if (core_ack) ack_cnt++;
            if (stray_ack) begin
                mem_ack   = 1'b1;
                mem_rdata = 8'hEE;
            end else if (ack_en && mem_req) begin
                wait_cnt++;
                if (wait_cnt == 2) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_addr[7:0] + 8'h2C;
                    log_q.push_back('{we: mem_we, addr: mem_addr, wdata: mem_wdata});
                    wait_cnt  = 0;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_txn(input string name, input int idx, input logic we,
                           input logic [23:0] addr, input logic [7:0] wdata);
        checks++;
        if (idx >= log_q.size()) begin
            errors++;
            $display("FAIL %s: transaction %0d missing, only %0d seen", name, idx, log_q.size());
        end else if (log_q[idx].we !== we || log_q[idx].addr !== addr ||
                     (we && log_q[idx].wdata !== wdata)) begin
            errors++;
            $display("FAIL %s: got we=%0b addr=0x%0h data=0x%0h, expected we=%0b addr=0x%0h data=0x%0h",
                     name, log_q[idx].we, log_q[idx].addr, log_q[idx].wdata, we, addr, wdata);
        end
    endtask

    task automatic wait_log(input string name, input int n, input int budget);
        int i;
        i = 0;
        while (log_q.size() < n && i < budget) begin
            tick(1);
            i++;
        end
        if (log_q.size() < n) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout, %0d transactions seen, expected %0d", name, log_q.size(), n);
        end
    endtask

    task automatic wait_core_ack(input string name, input int budget);
        int i;
        i = 0;
        while (core_ack !== 1'b1 && i < budget) begin
            tick(1);
            i++;
        end
        if (core_ack !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout waiting for core_ack, got 0 expected 1", name);
        end
    endtask

    task automatic wait_mem_req(input string name, input int budget);
        int i;
        i = 0;
        while (mem_req !== 1'b1 && i < budget) begin
            tick(1);
            i++;
        end
        if (mem_req !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout waiting for mem_req, got 0 expected 1", name);
        end
    endtask

    task automatic ioctl_write(input logic [26:0] a, input logic [7:0] d);
        ioctl_wr   = 1'b1;
        ioctl_addr = a;
        ioctl_dout = d;
        tick(1);
        ioctl_wr   = 1'b0;
    endtask

    initial begin
        vec_t dl_vec[3];
        vec_t map_vec[4];
        int   ack_base;

        dl_vec[0]  = '{27'h0000000, 8'hA5, 24'h200000};
        dl_vec[1]  = '{27'h0000001, 8'h5A, 24'h200001};
        dl_vec[2]  = '{27'h0000002, 8'hFF, 24'h200002};
        map_vec[0] = '{27'h7FFFFFF, 8'h11, 24'h1FFFFF};
        map_vec[1] = '{27'h0DFFFFF, 8'h22, 24'hFFFFFF};
        map_vec[2] = '{27'h0E00000, 8'h33, 24'h000000};
        map_vec[3] = '{27'h1000123, 8'h44, 24'h200123};

        reset = 1'b1; ioctl_download = 1'b0; ioctl_upload = 1'b0; ioctl_wr = 1'b0;
        ioctl_addr = '0; ioctl_dout = '0; core_req = 1'b0; core_we = 1'b0;
        core_addr = '0; core_wdata = '0;
        tick(3);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_core_ack", core_ack, 0);
        chk("rst_loader_busy", loader_busy, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_ioctl_din", ioctl_din, 0);
        reset = 1'b0;
        tick(1);

        // Basic download: three back-to-back strobes drain in order.
        ack_en = 1'b1;
        ioctl_download = 1'b1;
        tick(1);
        for (int i = 0; i < 3; i++) ioctl_write(dl_vec[i].addr, dl_vec[i].dout);
        ioctl_download = 1'b0;
        wait_log("dl_drain", 3, 40);
        chk("dl_busy_at_last_ack", loader_busy, 1);
        chk("dl_mem_req_dropped", mem_req, 0);
        tick(1);
        chk("dl_busy_fell", loader_busy, 0);
        for (int i = 0; i < 3; i++) chk_txn("dl_txn", i, 1'b1, dl_vec[i].exp_addr, dl_vec[i].dout);

        // Address translation including wrap modulo 2^24.
        log_q.delete();
        ioctl_download = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ioctl_write(map_vec[i].addr, map_vec[i].dout);
            wait_log("map_wait", i + 1, 20);
            chk_txn("map_txn", i, 1'b1, map_vec[i].exp_addr, map_vec[i].dout);
        end
        ioctl_download = 1'b0;
        tick(4);

        // Overflow: port held by an unacked core read, five strobes into a 4-deep FIFO.
        log_q.delete();
        ack_en    = 1'b0;
        core_req  = 1'b1;
        core_we   = 1'b0;
        core_addr = 24'h000100;
        tick(1);
        chk("ovf_core_mem_req", mem_req, 1);
        chk("ovf_core_mem_addr", mem_addr, 24'h000100);
        chk("ovf_core_mem_we", mem_we, 0);
        ioctl_download = 1'b1;
        for (int i = 0; i < 5; i++) ioctl_write(27'h20 + 27'(i), 8'h10 + 8'(i));
        chk("ovf_set", overflow, 1);
        chk("ovf_busy", loader_busy, 1);
        ack_en = 1'b1;
        wait_core_ack("ovf_core_ack", 20);
        chk("ovf_core_rdata", core_rdata, 8'h2C);
        core_req = 1'b0;
        tick(1);
        chk("ovf_core_ack_pulse", core_ack, 0);
        wait_log("ovf_drain", 5, 60);
        tick(10);
        chk("ovf_txn_count", log_q.size(), 5);
        for (int i = 0; i < 4; i++)
            chk_txn("ovf_txn", i + 1, 1'b1, 24'h200020 + 24'(i), 8'h10 + 8'(i));
        ioctl_download = 1'b0;
        tick(1);
        chk("ovf_sticky", overflow, 1);
        ioctl_download = 1'b1;
        tick(1);
        chk("ovf_cleared", overflow, 0);

        // Contention: core read waits behind two loader writes, one core_ack only.
        log_q.delete();
        ack_base = ack_cnt;
        ioctl_write(27'h30, 8'h66);
        core_req  = 1'b1;
        core_we   = 1'b0;
        core_addr = 24'h000100;
        ioctl_write(27'h31, 8'h77);
        wait_core_ack("cont_core_ack", 40);
        chk("cont_core_rdata", core_rdata, 8'h2C);
        core_req = 1'b0;
        ioctl_download = 1'b0;
        tick(10);
        chk("cont_txn_count", log_q.size(), 3);
        chk_txn("cont_wr0", 0, 1'b1, 24'h200030, 8'h66);
        chk_txn("cont_wr1", 1, 1'b1, 24'h200031, 8'h77);
        chk_txn("cont_core_rd", 2, 1'b0, 24'h000100, 8'h00);
        chk("cont_ack_pulses", ack_cnt - ack_base, 1);

        // Upload prefetch with an address change during the read.
        log_q.delete();
        ioctl_addr = 27'h10;
        tick(1);
        ioctl_upload = 1'b1;
        wait_mem_req("up_first_req", 10);
        chk("up_rd_addr0", mem_addr, 24'h200010);
        chk("up_rd_we0", mem_we, 0);
        ioctl_addr = 27'h11;
        wait_log("up_first_ack", 1, 10);
        chk("up_din0", ioctl_din, 8'h3C);
        wait_log("up_second_ack", 2, 20);
        chk("up_din1", ioctl_din, 8'h3D);
        chk_txn("up_rd1", 1, 1'b0, 24'h200011, 8'h00);
        tick(10);
        chk("up_txn_count", log_q.size(), 2);
        ioctl_upload = 1'b0;
        tick(2);
        chk("up_busy_fell", loader_busy, 0);

        // Reset while LD_WR is waiting for its ack, then a stray ack.
        log_q.delete();
        ack_en = 1'b0;
        ack_base = ack_cnt;
        ioctl_download = 1'b1;
        ioctl_write(27'h40, 8'hAB);
        ioctl_write(27'h41, 8'hCD);
        ioctl_download = 1'b0;
        chk("rm_mem_req", mem_req, 1);
        chk("rm_mem_we", mem_we, 1);
        chk("rm_mem_addr", mem_addr, 24'h200040);
        reset = 1'b1;
        tick(1);
        chk("rm_req_dropped", mem_req, 0);
        chk("rm_busy_cleared", loader_busy, 0);
        reset = 1'b0;
        stray_ack = 1'b1;
        tick(1);
        stray_ack = 1'b0;
        chk("rm_stray_no_core_ack", core_ack, 0);
        chk("rm_stray_no_req", mem_req, 0);
        ack_en = 1'b1;
        tick(8);
        chk("rm_fifo_flushed", log_q.size(), 0);
        chk("rm_no_req_later", mem_req, 0);
        chk("rm_busy_idle", loader_busy, 0);
        chk("rm_no_ack_pulses", ack_cnt - ack_base, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ioctl_mem_arbiter.md
Name: ioctl_mem_arbiter

Overview:
- Shares one memory port (SDRAM controller or BRAM wrapper) between the data_io ioctl stream and the core's own requester.
- Downloads: buffers ioctl_wr strobes in a small FIFO and retires them as memory writes.
- Uploads: prefetches the byte at ioctl_addr into ioctl_din before data_io samples it.
- Core requests are served when the loader has nothing pending. loader_busy tells the core when it may leave reset.

Parameters:
- AW, 24, memory address width; ioctl_addr is truncated to AW bits.
- ADDR_BASE, 0, offset added to ioctl_addr, modulo 2^AW.
- FIFO_LOG2, 2, log2 of download FIFO depth (default depth 4).

Ports:
- clk_sys  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- ioctl_download  in  1  download active.
- ioctl_upload  in  1  upload active.
- ioctl_wr  in  1  one-cycle write strobe.
- ioctl_addr  in  27  loader byte address.
- ioctl_dout  in  8  download byte.
- ioctl_din  out  8  prefetched upload byte.
- core_req  in  1  core request, held high until core_ack.
- core_we  in  1  core write (1) or read (0).
- core_addr  in  AW  core address.
- core_wdata  in  8  core write data.
- core_rdata  out  8  core read data, valid with core_ack.
- core_ack  out  1  one-cycle completion pulse.
- mem_req  out  1  memory request, held high until mem_ack.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  8  memory write data.
- mem_rdata  in  8  memory read data, valid with mem_ack.
- mem_ack  in  1  one-cycle completion pulse from memory.
- loader_busy  out  1  loader owns or will own the memory port.
- overflow  out  1  sticky: a download byte was dropped.

Behaviour:
- Reset values: all outputs 0; FIFO empty; state IDLE; rd_pend 0.
- Reset during a transaction: mem_req drops on the next edge. A later stray mem_ack is ignored, because acks are consumed only in busy states.
- FIFO push: on ioctl_wr && ioctl_download, push {ADDR_BASE + ioctl_addr[AW-1:0], ioctl_dout}.
  - Push while full: entry dropped, overflow set.
  - Push and pop in the same cycle are both honoured; count unchanged.
- overflow is cleared on the rising edge of ioctl_download.
- Upload prefetch:
  - Capture prev_addr every cycle.
  - Set rd_pend and latch rd_addr when ioctl_upload rises, or when ioctl_upload=1 and ioctl_addr != prev_addr.
  - On read completion, ioctl_din <= mem_rdata. rd_pend clears only if no new trigger occurred during the read; otherwise the read is reissued with the new rd_addr.
- FSM states: IDLE, LD_WR, LD_RD, CORE.
- IDLE, priority order:
  1. FIFO non-empty -> LD_WR: mem_we=1, address and data from FIFO head; pop when entering.
  2. rd_pend -> LD_RD: mem_we=0.
  3. core_req -> CORE: core_* copied to mem_*.
- mem_req is asserted on the edge that leaves IDLE.
- Busy states wait for mem_ack. On mem_ack: mem_req <= 0, return to IDLE.
  - CORE also pulses core_ack and, for reads, sets core_rdata <= mem_rdata.
- Minimum turnaround is one IDLE cycle between transactions. A core request issued while the FIFO is empty is not pre-empted.
- Core latency: core_req to mem_req is 1 cycle; mem_ack to core_ack is 1 cycle.
- Starvation: the core may wait through the entire download. This is acceptable because data_io produces at most one byte per clkref.
- loader_busy (registered) = ioctl_download | ioctl_upload | FIFO non-empty | rd_pend | state in {LD_WR, LD_RD}.
  - Its fall therefore follows the final write's mem_ack by one cycle.
- mem_addr, mem_we and mem_wdata are stable while mem_req=1.

Decomposition:
- Package ioctl_arb_pkg: FSM state enum; FIFO entry width constant (AW+8).
- Sub-module ioctl_wr_fifo: synchronous FIFO, depth 2^FIFO_LOG2, with push/pop/full/empty. It uses the same clock and synchronous reset.

Test Plan:
- Basic download: 3 ioctl_wr at addr 0,1,2, data A5,5A,FF, mem_ack 2 cycles after each mem_req -> three mem writes in order at addr 0..2; loader_busy falls 1 cycle after the last ack once ioctl_download=0.
- Overflow: mem_ack withheld, 5 ioctl_wr with FIFO_LOG2=2 -> 4 buffered, 5th dropped, overflow=1; it clears on the next ioctl_download rise.
- Upload: ioctl_upload rises at addr 0x10, memory returns 3C -> ioctl_din=3C. Address changes to 0x11 mid-read -> second read issued at 0x11, and ioctl_din ends at that byte.
- Contention: core_req read at 0x100 while the FIFO holds 2 entries -> both loader writes complete first, then the core read; core_ack is a single pulse with core_rdata=mem_rdata.
- Reset mid-transaction: reset asserted while mem_req=1 in LD_WR -> mem_req=0 next cycle, FIFO empty, a stray mem_ack next cycle causes no core_ack and no state change.
- ADDR_BASE=0x200000, ioctl_addr=0x7FFFFFF, AW=24 -> mem_addr=0x1FFFFF (wrap modulo 2^24).
